// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debouncer: FSM encoding, parameter limits and
// a counter-width helper that downstream benches can reuse.
package debounce_sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } db_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DB_CYCLES_MIN   = 1;
  localparam int DB_CYCLES_MAX   = 65535;

  // Smallest width able to hold the value n (at least 1 bit).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; cleared by reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_sync <= '0;
    else      r_sync <= {r_sync[STAGES-2:0], D};
  end

  assign Q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes a raw input and only moves Q after DB_CYCLES consecutive
// samples disagree with it; RISE/FALL mark the first cycle of a new level.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic D_IN,
  output logic Q,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int            CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          w_s;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (D_IN),
    .Q   (w_s)
  );

  // Outputs are registered alongside the state so nothing downstream sees
  // a combinational path from the synchronizer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      Q       <= 1'b0;
      RISE    <= 1'b0;
      FALL    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      case (r_state)
        STABLE_LO: if (w_s) begin
          if (DB_CYCLES == 1) begin
            r_state <= STABLE_HI;
            Q       <= 1'b1;
            RISE    <= 1'b1;
          end else begin
            r_state <= WAIT_HI;
            r_cnt   <= CW'(1);
            BUSY    <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (!w_s) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            Q       <= 1'b1;
            RISE    <= 1'b1;
            BUSY    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STABLE_HI: if (!w_s) begin
          if (DB_CYCLES == 1) begin
            r_state <= STABLE_LO;
            Q       <= 1'b0;
            FALL    <= 1'b1;
          end else begin
            r_state <= WAIT_LO;
            r_cnt   <= CW'(1);
            BUSY    <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (w_s) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            Q       <= 1'b0;
            FALL    <= 1'b1;
            BUSY    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          Q       <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench: two debouncers (DB_CYCLES=4 and 1) share one input and
// are checked every cycle against a run-length reference model.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int NDUT = 2;

  typedef struct packed {
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } obs_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic D_IN = 1'b0;
  logic q_o [NDUT];
  logic rise_o [NDUT];
  logic fall_o [NDUT];
  logic busy_o [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  debounce_sync #(.SYNC_STAGES(SYNC), .DB_CYCLES(4)) u_db4 (
    .CLK(CLK), .RST(RST), .D_IN(D_IN),
    .Q(q_o[0]), .RISE(rise_o[0]), .FALL(fall_o[0]), .BUSY(busy_o[0]));

  debounce_sync #(.SYNC_STAGES(SYNC), .DB_CYCLES(1)) u_db1 (
    .CLK(CLK), .RST(RST), .D_IN(D_IN),
    .Q(q_o[1]), .RISE(rise_o[1]), .FALL(fall_o[1]), .BUSY(busy_o[1]));

  // Reference: s is D_IN delayed SYNC edges; Q flips once s has disagreed
  // with it for DB consecutive edges.
  int   db_of [NDUT] = '{4, 1};
  logic m_q   [NDUT];
  int   m_run [NDUT];
  logic m_sh  [NDUT][SYNC];
  obs_t exp_q [NDUT][$];

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_q[k] = 1'b0;
      m_run[k] = 0;
      for (int i = 0; i < SYNC; i++) m_sh[k][i] = 1'b0;
      exp_q[k].delete();
    end
  endtask

  task automatic model_step(input logic d);
    logic s;
    obs_t e;
    for (int k = 0; k < NDUT; k++) begin
      s = m_sh[k][SYNC-1];
      e = '0;
      if (s != m_q[k]) begin
        m_run[k]++;
        if (m_run[k] == db_of[k]) begin
          m_q[k] = s;
          m_run[k] = 0;
          e.rise = s;
          e.fall = !s;
        end
      end else begin
        m_run[k] = 0;
      end
      e.q = m_q[k];
      e.busy = (m_run[k] != 0);
      for (int i = SYNC - 1; i > 0; i--) m_sh[k][i] = m_sh[k][i-1];
      m_sh[k][0] = d;
      exp_q[k].push_back(e);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive, predict the coming edge, wait past it.
  task automatic drive(input logic d);
    D_IN = d;
    model_step(d);
    @(negedge CLK);
  endtask

  // Monitor: pop and compare after every rising edge, plus pulse properties.
  logic prev_q [NDUT] = '{1'b0, 1'b0};
  initial begin
    obs_t e, a;
    forever begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        a = '{q_o[k], rise_o[k], fall_o[k], busy_o[k]};
        if (exp_q[k].size() > 0) begin
          e = exp_q[k].pop_front();
          chk($sformatf("sb_dut%0d", k), int'(a), int'(e));
          chk($sformatf("overlap_dut%0d", k), int'(a.rise & a.fall), 0);
          chk($sformatf("rise_no_edge_dut%0d", k),
              int'(a.rise & !(a.q & !prev_q[k])), 0);
          chk($sformatf("fall_no_edge_dut%0d", k),
              int'(a.fall & !(!a.q & prev_q[k])), 0);
        end
        prev_q[k] = a.q;
      end
    end
  end

  task automatic chk_all_zero(input string name);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("%s_dut%0d", name, k),
          int'({q_o[k], rise_o[k], fall_o[k], busy_o[k]}), 0);
  endtask

  int exp_q27    [7] = '{0, 0, 0, 0, 0, 1, 1};
  int exp_rise27 [7] = '{0, 0, 0, 0, 0, 1, 0};
  int exp_busy27 [7] = '{0, 0, 1, 1, 1, 0, 0};

  initial begin
    int len;
    logic lvl;
    model_reset();
    #1 chk_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0);

    // Clean rising edge with DB_CYCLES=4: Q moves after edge 6.
    for (int e = 0; e < 7; e++) begin
      drive(1'b1);
      chk($sformatf("rise_q_e%0d", e + 1), int'(q_o[0]), exp_q27[e]);
      chk($sformatf("rise_pulse_e%0d", e + 1), int'(rise_o[0]), exp_rise27[e]);
      chk($sformatf("rise_busy_e%0d", e + 1), int'(busy_o[0]), exp_busy27[e]);
    end

    // Falling edge, then a short re-high that must be rejected.
    for (int e = 1; e <= 6; e++) begin
      drive(1'b0);
      chk($sformatf("fall_pulse_e%0d", e), int'(fall_o[0]), (e == 6) ? 1 : 0);
    end
    drive(1'b1);
    drive(1'b1);
    for (int e = 0; e < 8; e++) begin
      drive(1'b0);
      chk("glitch_hi_q", int'(q_o[0]), 0);
      chk("glitch_hi_rise", int'(rise_o[0]), 0);
    end

    // 3-cycle pulse is shorter than DB_CYCLES=4.
    for (int e = 0; e < 3; e++) drive(1'b1);
    for (int e = 0; e < 6; e++) begin
      drive(1'b0);
      chk("short_pulse_q", int'(q_o[0]), 0);
      chk("short_pulse_rise", int'(rise_o[0]), 0);
    end
    chk("short_pulse_busy", int'(busy_o[0]), 0);

    // Reset mid-qualification (cnt=2 after four edges of D_IN=1).
    for (int e = 0; e < 4; e++) drive(1'b1);
    chk("pre_reset_busy", int'(busy_o[0]), 1);
    #2 RST = 1'b0;
    #1 chk_all_zero("mid_reset");
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      drive(1'b1);
      chk($sformatf("post_reset_q_e%0d", e), int'(q_o[0]), (e == 6) ? 1 : 0);
    end
    chk("post_reset_rise", int'(rise_o[0]), 1);

    // Random runs, biased toward lengths around the qualification window.
    len = 0;
    lvl = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (len == 0) begin
        lvl = ~lvl;
        len = $urandom_range(1, 8);
      end
      drive(lvl);
      len--;
    end
    drive(1'b0);
    drive(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flip-flops (legal range 2..4).
REQ-002 The block SHALL have parameter DB_CYCLES, default 16, number of consecutive agreeing synchronized samples required before the output changes (legal range 1..65535).
REQ-003 The block SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port D_IN  input  1  raw asynchronous input (button, switch, or external pin).
REQ-006 The block SHALL have port Q  output  1  debounced, synchronized level, registered.
REQ-007 The block SHALL have port RISE  output  1  single-cycle pulse coincident with the first cycle Q=1 after Q=0.
REQ-008 The block SHALL have port FALL  output  1  single-cycle pulse coincident with the first cycle Q=0 after Q=1.
REQ-009 The block SHALL have port BUSY  output  1  high while a candidate transition is being qualified (WAIT states).

Function
REQ-010 D_IN SHALL pass through a chain of SYNC_STAGES flip-flops; the last stage output is s, and no other logic SHALL read D_IN or the intermediate stages.
REQ-011 The FSM SHALL have four states: STABLE_LO (Q=0), WAIT_HI (Q=0, BUSY=1), STABLE_HI (Q=1), WAIT_LO (Q=1, BUSY=1).
REQ-012 The counter cnt SHALL count consecutive samples in which s differs from Q; its width SHALL be the minimum needed to hold DB_CYCLES, and it SHALL never wrap.
REQ-013 In STABLE_LO with s=1: if DB_CYCLES=1, go to STABLE_HI; otherwise go to WAIT_HI with cnt=1.
REQ-014 In WAIT_HI with s=1: increment cnt; when the sample makes the count equal DB_CYCLES, go to STABLE_HI and clear cnt.
REQ-015 In WAIT_HI with s=0: return to STABLE_LO and clear cnt (glitch rejected; Q, RISE, and FALL unaffected).
REQ-016 STABLE_HI and WAIT_LO SHALL mirror REQ-013..015 with s polarity inverted.
REQ-017 Latency from a clean D_IN edge (setup met) to the Q change SHALL be exactly SYNC_STAGES+DB_CYCLES rising CLK edges.
REQ-018 RISE and FALL SHALL be registered, high for exactly one cycle, never simultaneously high, and never asserted without a Q change.
REQ-019 A D_IN pulse shorter than DB_CYCLES synchronized cycles SHALL produce no Q, RISE, or FALL activity.
REQ-020 A continuously toggling s SHALL keep the FSM alternating between STABLE and WAIT states without Q changing.

Reset
REQ-021 RST=0 SHALL immediately clear all synchronizer stages, cnt, and the FSM to STABLE_LO; Q, RISE, FALL, and BUSY SHALL be 0.
REQ-022 Reset asserted mid-qualification SHALL abandon the pending transition with no pulse emitted.
REQ-023 After RST deasserts with D_IN=1, Q SHALL rise after SYNC_STAGES+DB_CYCLES edges, accompanied by one RISE pulse.

Structure
REQ-024 The FSM state encoding (4-value enum) and the legal-range limits of the parameters SHALL reside in a shared package, so that downstream flip-flop test benches can reuse them.
REQ-025 The synchronizer chain SHALL be a separate sub-module, sync_chain (parameter STAGES, ports CLK, RST, D, Q), instantiated once.
REQ-026 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from D_IN to any output.

Verification
REQ-027 With SYNC_STAGES=2, DB_CYCLES=4, drive D_IN 0->1 before edge 1 -> Q=1 and RISE=1 after edge 6, RISE=0 after edge 7, BUSY=1 after edges 3..5.
REQ-028 With D_IN high for 3 cycles then low (DB_CYCLES=4) -> Q stays 0, no RISE, BUSY returns to 0.
REQ-029 With Q=1 stable, drive D_IN low -> FALL pulses once after 6 edges; an immediate re-high 2 cycles later is rejected.
REQ-030 With RST=0 asserted during WAIT_HI (cnt=2) -> all outputs 0 at once; after release with D_IN=1, Q rises 6 edges later.
REQ-031 With DB_CYCLES=1 -> Q follows D_IN delayed by 3 edges; RISE and FALL pulse on every change.
REQ-032 Apply 10k cycles of random D_IN with a reference model -> Q, RISE, FALL, and BUSY match the model every cycle, and the no-overlap and one-cycle properties hold.
